// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes OR1K shifts, resolves operands and queues them in a 2-entry skid buffer.
// Define SHIFT_ISSUE_FWD_EN to enable the fwd* bypass path.
module shift_issue_stage #(
    parameter int DEPTH_LOG2 = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instruction,
    input  logic [31:0] regAData,
    input  logic [31:0] regBData,
    input  logic        fwdValid,
    input  logic [4:0]  fwdReg,
    input  logic [31:0] fwdData,
    output logic        outValid,
    input  logic        outReady,
    output logic [1:0]  shiftControl,
    output logic [31:0] operantA,
    output logic [31:0] operantB,
    output logic [4:0]  destReg
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
    } entry_t;

    if (DEPTH_LOG2 != 1) begin : g_depth_check
        $error("shift_issue_stage supports only DEPTH_LOG2 == 1");
    end

    state_t state_q, state_d;
    entry_t head_q, head_d, tail_q, tail_d, new_entry;
    logic is_reg, is_imm, accept, pop, write, hit_a, hit_b, unused;
    logic [4:0] idx_a, idx_b;

    assign idx_a = instruction[20:16];
    assign idx_b = instruction[15:11];
    assign is_reg = instruction[31:26] == 6'h38 && instruction[9:8] == 2'b00 && instruction[3:0] == 4'h8;
    assign is_imm = instruction[31:26] == 6'h2E;

`ifdef SHIFT_ISSUE_FWD_EN
    assign hit_a = fwdValid && fwdReg == idx_a;
    assign hit_b = fwdValid && fwdReg == idx_b;
    assign unused = ^{instruction[10], instruction[5]};
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign unused = ^{instruction[10], instruction[5], fwdValid, fwdReg};
`endif

    // r0 wins over any bypass match, so a forward to r0 is ignored
    always_comb begin
        new_entry.ctrl = instruction[7:6];
        new_entry.dest = instruction[25:21];
        new_entry.a = idx_a == 5'd0 ? 32'h0 : hit_a ? fwdData : regAData;
        new_entry.b = is_imm ? {27'b0, instruction[4:0]} :
                      idx_b == 5'd0 ? 32'h0 : hit_b ? fwdData : regBData;
    end

    assign inReady  = state_q != TWO && !reset && !flush;
    assign outValid = state_q != EMPTY;
    assign accept   = inValid && inReady;
    assign pop      = outValid && outReady;
    assign write    = accept && (is_reg || is_imm);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                state_d = write ? ONE : EMPTY;
                head_d  = write ? new_entry : head_q;
            end
            ONE: begin
                state_d = write && !pop ? TWO : !write && pop ? EMPTY : ONE;
                head_d  = write && pop ? new_entry : head_q;
                tail_d  = write && !pop ? new_entry : tail_q;
            end
            TWO: begin
                state_d = pop ? ONE : TWO;
                head_d  = pop ? tail_q : head_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign shiftControl = head_q.ctrl;
    assign operantA     = head_q.a;
    assign operantB     = head_q.b;
    assign destReg      = head_q.dest;
endmodule
